// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: in-order req/gnt/rvalid instruction-memory port.
interface if_fetch_unit_if #(parameter int XLEN = 32);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    modport master(output req, addr, input gnt, rvalid, rdata);
    modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, imem requester and fetch buffer feeding the IF/ID register.
module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter int              MAX_OUTST  = 2,
    parameter logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    if_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]  if_pc_out,
    output logic [XLEN-1:0]  if_instr_out,
    output logic             if_valid_out,
    output logic             if_id_flush
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int QW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
    typedef enum logic {FETCH, DRAIN} state_t;
    state_t          state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outst, count, drop, drop_next;
    logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
    logic [FW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] pc_q [MAX_OUTST];
    logic [QW-1:0]   q_rd, q_wr;
    logic            valid, accept, resp, push, pop;
    always_comb begin
        valid        = (count != '0) & ~reset;
        imem.req     = ~reset & (state == FETCH) & ~redirect_valid & (outst < CW'(MAX_OUTST))
                       & ({1'b0, outst} + {1'b0, count} < (CW+1)'(FIFO_DEPTH));
        imem.addr    = pc;
        accept       = imem.req & imem.gnt;
        resp         = imem.rvalid & (outst != '0);
        push         = resp & (drop == '0) & ~redirect_valid;
        pop          = valid & ~stall;
        // a redirect turns every word still in flight (minus one arriving now) into stale data
        drop_next    = redirect_valid ? outst - CW'(resp) : drop - CW'(resp & (drop != '0));
        if_valid_out = valid;
        if_pc_out    = valid ? fifo_pc[rd_ptr] : '0;
        if_instr_out = valid ? fifo_instr[rd_ptr] : NOP_INSTR;
        if_id_flush  = redirect_valid & ~reset;
    end
    always_ff @(posedge clock) begin
        if (accept) pc_q[q_wr] <= pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_q[q_rd];
            fifo_instr[wr_ptr] <= imem.rdata;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            outst  <= '0;
            count  <= '0;
            drop   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_rd   <= '0;
            q_wr   <= '0;
        end else begin
            outst <= outst + CW'(accept) - CW'(resp);
            drop  <= drop_next;
            if (accept) q_wr <= (q_wr == QW'(MAX_OUTST - 1)) ? '0 : q_wr + QW'(1);
            if (resp) q_rd <= (q_rd == QW'(MAX_OUTST - 1)) ? '0 : q_rd + QW'(1);
            if (redirect_valid) begin
                pc     <= {redirect_pc[XLEN-1:2], 2'b00};
                count  <= '0;
                rd_ptr <= wr_ptr;
                state  <= (drop_next != '0) ? DRAIN : FETCH;
            end else begin
                if (accept) pc <= pc + XLEN'(4);
                if (push) wr_ptr <= wr_ptr + FW'(1);
                if (pop) rd_ptr <= rd_ptr + FW'(1);
                count <= count + CW'(push) - CW'(pop);
                state <= (state == DRAIN && drop_next == '0) ? FETCH : state;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random and directed stimulus against a request/epoch queue model of the fetch stage.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clock = 0, reset = 1, stall = 0, redirect_valid = 0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_pc_out, if_instr_out, pc2, instr2;
    logic if_valid_out, if_id_flush, valid2, flush2;
    int checks = 0, passes = 0;
    logic [31:0] rq_addr[$];
    int          rq_epoch[$];
    logic [31:0] out_q[$];
    logic [31:0] exp_pc = '0;
    int          epoch = 0;

    if_fetch_unit_if #(.XLEN(32)) imem();
    if_fetch_unit_if #(.XLEN(32)) imem2();

    if_fetch_unit dut (.clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem(imem), .if_pc_out(if_pc_out), .if_instr_out(if_instr_out),
        .if_valid_out(if_valid_out), .if_id_flush(if_id_flush));
    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clock(clock), .reset(reset), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .imem(imem2), .if_pc_out(pc2), .if_instr_out(instr2),
        .if_valid_out(valid2), .if_id_flush(flush2));
    assign imem2.gnt    = 1'b1;
    assign imem2.rvalid = 1'b0;
    assign imem2.rdata  = '0;

    always #5 clock = ~clock;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: every granted request carries the redirect epoch it was issued in; only
    // current-epoch words reach the output queue.
    always @(negedge clock) begin
        int stale;
        bit exp_req, deliver;
        logic [31:0] a;
        int e;
        if (reset) begin
            check("rst_valid", if_valid_out, 0);
            check("rst_instr", if_instr_out, NOP);
            check("rst_pc", if_pc_out, 0);
            check("rst_req", imem.req, 0);
            check("rst_flush", if_id_flush, 0);
            rq_addr.delete(); rq_epoch.delete(); out_q.delete();
            exp_pc = 32'h0;
            epoch  = 0;
        end else begin
            stale = 0;
            foreach (rq_epoch[i]) if (rq_epoch[i] != epoch) stale++;
            exp_req = !redirect_valid && stale == 0 && rq_addr.size() < 2 && rq_addr.size() + out_q.size() < 2;
            check("req", imem.req, exp_req);
            if (exp_req) check("addr", imem.addr, exp_pc);
            check("flush", if_id_flush, redirect_valid);
            check("valid", if_valid_out, out_q.size() != 0);
            check("head_pc", if_pc_out, out_q.size() != 0 ? out_q[0] : 32'h0);
            check("head_instr", if_instr_out, out_q.size() != 0 ? instr_of(out_q[0]) : NOP);
            deliver = 0;
            a = '0;
            if (imem.rvalid) begin
                check("rvalid_outst", rq_addr.size() != 0, 1);
                if (rq_addr.size() != 0) begin
                    deliver = rq_epoch[0] == epoch && !redirect_valid;
                    a = rq_addr.pop_front();
                    e = rq_epoch.pop_front();
                end
            end
            if (redirect_valid) begin
                epoch++;
                out_q.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_q.size() != 0 && !stall) a = deliver ? a : out_q.pop_front();
                if (out_q.size() != 0 && !stall && deliver) void'(out_q.pop_front());
                if (deliver) out_q.push_back(a);
                if (exp_req && imem.gnt) begin
                    rq_addr.push_back(exp_pc);
                    rq_epoch.push_back(epoch);
                    exp_pc += 32'd4;
                end
            end
        end
    end

    task automatic step(input bit st, input bit rd, input logic [31:0] rp, input int gp, input int vp);
        @(posedge clock); #1;
        reset          = 0;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rp;
        imem.gnt       = $urandom_range(99) < gp;
        imem.rvalid    = rq_addr.size() != 0 && $urandom_range(99) < vp;
        imem.rdata     = imem.rvalid ? instr_of(rq_addr[0]) : $urandom;
    endtask

    task automatic hold_reset(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            reset = 1; stall = 0; redirect_valid = 0; imem.gnt = 0; imem.rvalid = 0;
        end
    endtask

    initial begin
        imem.gnt = 0; imem.rvalid = 0; imem.rdata = '0;
        hold_reset(2);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t1_addr0", imem.addr, 32'h0);
        check("t1_req0", imem.req, 1);
        check("t5_addr0", imem2.addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t1_addr1", imem.addr, 32'h4);
        check("t5_addr_wrap", imem2.addr, 32'h0);
        check("t5_req1", imem2.req, 1);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t1_valid2", if_valid_out, 1);
        check("t1_pc2", if_pc_out, 32'h0);
        check("t1_instr2", if_instr_out, 32'h5A5A_0013);
        repeat (20) step(0, 0, 0, 100, 100);
        repeat (5) step(1, 0, 0, 100, 100);
        @(negedge clock);
        check("t2_req_full", imem.req, 0);
        check("t2_valid_held", if_valid_out, 1);
        repeat (4) step(0, 0, 0, 100, 0);
        step(0, 1, 32'h100, 100, 0); @(negedge clock);
        check("t3_flush", if_id_flush, 1);
        check("t3_req_off", imem.req, 0);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t3_flush_off", if_id_flush, 0);
        step(0, 0, 0, 100, 100);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t3_addr", imem.addr, 32'h100);
        check("t3_req", imem.req, 1);
        step(0, 0, 0, 100, 100);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t3_first_pc", if_pc_out, 32'h100);
        check("t3_first_valid", if_valid_out, 1);
        step(0, 0, 0, 100, 0);
        step(0, 1, 32'h203, 100, 100); @(negedge clock);
        check("t4_rvalid", imem.rvalid, 1);
        step(0, 0, 0, 100, 100); @(negedge clock);
        check("t4_addr", imem.addr, 32'h200);
        check("t4_valid_none", if_valid_out, 0);
        repeat (3000) step($urandom_range(99) < 30, $urandom_range(99) < 3, $urandom, 60, 50);
        repeat (4) step(0, 0, 0, 0, 100);
        repeat (4) begin
            step(0, 0, 0, 0, 100); @(negedge clock);
            check("t6_req_wait", imem.req, 1);
            check("t6_addr_hold", imem.addr, exp_pc);
        end
        repeat (3) step(0, 0, 0, 100, 100);
        hold_reset(1);
        step(0, 0, 0, 0, 0); @(negedge clock);
        check("t6_valid", if_valid_out, 0);
        check("t6_addr", imem.addr, 32'h0);
        check("t6_req", imem.req, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
